// File: rtl/mem_resp_pkg.sv
// Shared types and constants for the cache-miss memory responder.
package mem_resp_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StRlat,
    StRburst,
    StWburst,
    StWbusy
  } resp_state_e;

  localparam logic [7:0] LfsrSeed = 8'hA5;
  // Feedback taps 8,6,5,4 of a left-shifting Fibonacci LFSR (bits 7,5,4,3).
  localparam logic [7:0] LfsrTaps = 8'hB8;

  function automatic int unsigned log2_of(input int unsigned v);
    return $clog2(v);
  endfunction

  function automatic logic [7:0] lfsr_next(input logic [7:0] q);
    return {q[6:0], ^(q & LfsrTaps)};
  endfunction

endpackage

// File: rtl/resp_word_ram.sv
// Single-port word store with a one-cycle registered read port.
module resp_word_ram #(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned DATA_W      = 32
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  logic                           we_i,
  input  logic                           re_i,
  input  logic [$clog2(DEPTH_WORDS)-1:0] addr_i,
  input  logic [DATA_W-1:0]              wdata_i,
  output logic [DATA_W-1:0]              rdata_o
);

  logic [DATA_W-1:0] mem_q [DEPTH_WORDS];
  logic [DATA_W-1:0] rdata_q;

  // Contents are never reset; only the read register clears.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[addr_i] <= wdata_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rdata_q <= '0;
    end else if (re_i) begin
      rdata_q <= mem_q[addr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/mem_line_responder.sv
// Line-burst memory responder for the cache-miss port.
// Optional latency jitter from an 8-bit LFSR when MEM_RESP_JITTER_EN is defined.
module mem_line_responder
  import mem_resp_pkg::*;
#(
  parameter int unsigned ADDR_W      = 32,
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned LINE_WORDS  = 4,
  parameter int unsigned LATENCY     = 4,
  parameter int unsigned DEPTH_WORDS = 1024
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_m_read,
  input  logic              i_m_write,
  input  logic [ADDR_W-1:0] i_m_addr,
  input  logic [DATA_W-1:0] i_m_writedata,
  output logic              o_m_waitrequest,
  output logic [DATA_W-1:0] o_m_readdata,
  output logic              o_m_readdatavalid,
  output logic              o_m_error
);

  localparam int unsigned AW  = log2_of(DEPTH_WORDS);
  localparam int unsigned LWB = log2_of(LINE_WORDS);
  localparam int unsigned NW  = AW - LWB;
  localparam int unsigned CW  = log2_of(LATENCY + 4) + 1;

  localparam logic [CW-1:0]  LatC     = CW'(LATENCY);
  localparam logic [CW-1:0]  CntOne   = CW'(1);
  localparam logic [LWB-1:0] BeatLast = LWB'(LINE_WORDS - 1);
  localparam logic [LWB-1:0] BeatOne  = LWB'(1);

  resp_state_e state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [CW-1:0]  wlat_q, wlat_d;
  logic [LWB-1:0] beat_q, beat_d;
  logic [NW-1:0]  line_q, line_d;
  logic           err_q, err_d;

  logic [NW-1:0]     line_in;
  logic [CW-1:0]     jit_now;
  logic [CW-1:0]     lat_eff;
  logic              ram_we, ram_re;
  logic [AW-1:0]     ram_addr;
  logic [DATA_W-1:0] ram_rdata;
  logic              unused_addr;

  assign line_in     = i_m_addr[2+LWB +: NW];
  assign unused_addr = ^{i_m_addr[1:0], i_m_addr[2 +: LWB], i_m_addr[ADDR_W-1:AW+2]};

`ifdef MEM_RESP_JITTER_EN
  logic [7:0] lfsr_q;
  logic       unused_lfsr;

  always_ff @(posedge clk) begin
    if (rst) begin
      lfsr_q <= LfsrSeed;
    end else begin
      lfsr_q <= lfsr_next(lfsr_q);
    end
  end

  assign jit_now     = {{(CW-2){1'b0}}, lfsr_q[1:0]};
  assign unused_lfsr = ^lfsr_q[7:2];
`else
  assign jit_now = '0;
`endif

  assign lat_eff = LatC + jit_now;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      wlat_q  <= LatC;
      beat_q  <= '0;
      line_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      wlat_q  <= wlat_d;
      beat_q  <= beat_d;
      line_q  <= line_d;
      err_q   <= err_d;
    end
  end

  // Read words are fetched one cycle ahead of their valid cycle to cover the RAM read register.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    wlat_d   = wlat_q;
    beat_d   = beat_q;
    line_d   = line_q;
    err_d    = err_q;
    ram_we   = 1'b0;
    ram_re   = 1'b0;
    ram_addr = {line_q, beat_q};

    unique case (state_q)
      StIdle: begin
        if (i_m_read) begin
          line_d   = line_in;
          beat_d   = '0;
          err_d    = err_q | i_m_write;
          ram_addr = {line_in, {LWB{1'b0}}};
          if (lat_eff == CntOne) begin
            ram_re  = 1'b1;
            state_d = StRburst;
          end else begin
            cnt_d   = lat_eff - CntOne;
            state_d = StRlat;
          end
        end else if (i_m_write) begin
          line_d   = line_in;
          beat_d   = BeatOne;
          wlat_d   = lat_eff;
          ram_we   = 1'b1;
          ram_addr = {line_in, {LWB{1'b0}}};
          state_d  = StWburst;
        end
      end
      StRlat: begin
        ram_addr = {line_q, {LWB{1'b0}}};
        if (cnt_q == CntOne) begin
          ram_re  = 1'b1;
          state_d = StRburst;
        end else begin
          cnt_d = cnt_q - CntOne;
        end
      end
      StRburst: begin
        ram_addr = {line_q, beat_q + BeatOne};
        if (beat_q == BeatLast) begin
          state_d = StIdle;
        end else begin
          ram_re = 1'b1;
          beat_d = beat_q + BeatOne;
        end
      end
      StWburst: begin
        err_d = err_q | i_m_read;
        if (i_m_write) begin
          ram_we = 1'b1;
          beat_d = beat_q + BeatOne;
          if (beat_q == BeatLast) begin
            cnt_d   = wlat_q;
            state_d = StWbusy;
          end
        end
      end
      StWbusy: begin
        if (cnt_q == CntOne) begin
          state_d = StIdle;
        end else begin
          cnt_d = cnt_q - CntOne;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  resp_word_ram #(
    .DEPTH_WORDS(DEPTH_WORDS),
    .DATA_W     (DATA_W)
  ) u_ram (
    .clk_i  (clk),
    .rst_i  (rst),
    .we_i   (ram_we & ~rst),
    .re_i   (ram_re & ~rst),
    .addr_i (ram_addr),
    .wdata_i(i_m_writedata),
    .rdata_o(ram_rdata)
  );

  assign o_m_waitrequest   = rst | (state_q inside {StRlat, StRburst, StWbusy});
  assign o_m_readdatavalid = ~rst & (state_q == StRburst);
  assign o_m_readdata      = ram_rdata;
  assign o_m_error         = err_q;

endmodule

// File: tb/tb_mem_line_responder.sv
// Randomized bench for mem_line_responder against a cycle-level transaction model.
module tb_mem_line_responder;

  localparam int unsigned LAT   = 4;
  localparam int unsigned LW    = 4;
  localparam int unsigned DEPTH = 1024;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        i_m_read = 1'b0;
  logic        i_m_write = 1'b0;
  logic [31:0] i_m_addr = '0;
  logic [31:0] i_m_writedata = '0;
  logic        o_m_waitrequest;
  logic [31:0] o_m_readdata;
  logic        o_m_readdatavalid;
  logic        o_m_error;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  logic [31:0] mem_m [DEPTH];
  logic [31:0] last_m = '0;
  logic        err_m = 1'b0;
  logic [31:0] wbuf [LW];

  mem_line_responder #(
    .ADDR_W     (32),
    .DATA_W     (32),
    .LINE_WORDS (LW),
    .LATENCY    (LAT),
    .DEPTH_WORDS(DEPTH)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .i_m_read         (i_m_read),
    .i_m_write        (i_m_write),
    .i_m_addr         (i_m_addr),
    .i_m_writedata    (i_m_writedata),
    .o_m_waitrequest  (o_m_waitrequest),
    .o_m_readdata     (o_m_readdata),
    .o_m_readdatavalid(o_m_readdatavalid),
    .o_m_error        (o_m_error)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Drive one cycle of inputs, then settle before sampling.
  task automatic tick(input logic r, input logic rd, input logic wr,
                      input logic [31:0] a, input logic [31:0] wd);
    @(negedge clk);
    rst           = r;
    i_m_read      = rd;
    i_m_write     = wr;
    i_m_addr      = a;
    i_m_writedata = wd;
    #1;
  endtask

  task automatic check_cycle(input string tag, input logic exp_wait, input logic exp_valid,
                             input logic [31:0] exp_word);
    check({tag, "_wait"}, {31'd0, o_m_waitrequest}, {31'd0, exp_wait});
    check({tag, "_valid"}, {31'd0, o_m_readdatavalid}, {31'd0, exp_valid});
    if (exp_valid) last_m = exp_word;
    check({tag, "_data"}, o_m_readdata, last_m);
    check({tag, "_err"}, {31'd0, o_m_error}, {31'd0, err_m});
  endtask

  function automatic int unsigned base_of(input logic [31:0] a);
    int unsigned idx;
    idx = (a >> 2) % DEPTH;
    return idx - (idx % LW);
  endfunction

  function automatic logic rbit();
    return logic'($urandom_range(0, 1));
  endfunction

  task automatic do_read(input logic [31:0] a, input logic also_write, input logic [31:0] wd);
    int unsigned b;
    logic v;
    b = base_of(a);
    tick(1'b0, 1'b1, also_write, a, wd);
    check_cycle("rd_req", 1'b0, 1'b0, '0);
    if (also_write) err_m = 1'b1;
    for (int k = 1; k <= int'(LAT + LW - 1); k++) begin
      tick(1'b0, rbit(), rbit(), $urandom, $urandom);
      v = (k >= int'(LAT));
      check_cycle("rd", 1'b1, v, v ? mem_m[b + k - LAT] : 32'h0);
    end
  endtask

  // Writes wbuf as one line; pauses pause_len cycles after word pause_after.
  task automatic do_write(input logic [31:0] a, input int pause_after, input int pause_len,
                          input logic rd_in_pause);
    int unsigned b;
    b = base_of(a);
    tick(1'b0, 1'b0, 1'b1, a, wbuf[0]);
    check_cycle("wr_req", 1'b0, 1'b0, '0);
    mem_m[b] = wbuf[0];
    for (int k = 1; k < int'(LW); k++) begin
      if (k - 1 == pause_after) begin
        for (int p = 0; p < pause_len; p++) begin
          tick(1'b0, rd_in_pause && p == 0, 1'b0, $urandom, $urandom);
          check_cycle("wr_pause", 1'b0, 1'b0, '0);
          if (rd_in_pause && p == 0) err_m = 1'b1;
        end
      end
      tick(1'b0, 1'b0, 1'b1, $urandom, wbuf[k]);
      check_cycle("wr_word", 1'b0, 1'b0, '0);
      mem_m[b + k] = wbuf[k];
    end
    for (int k = 1; k <= int'(LAT); k++) begin
      tick(1'b0, rbit(), rbit(), $urandom, $urandom);
      check_cycle("wr_busy", 1'b1, 1'b0, '0);
    end
  endtask

  task automatic apply_reset(input int cycles);
    for (int k = 0; k < cycles; k++) begin
      tick(1'b1, rbit(), rbit(), $urandom, $urandom);
      check("rst_wait", {31'd0, o_m_waitrequest}, 32'd1);
      check("rst_valid", {31'd0, o_m_readdatavalid}, 32'd0);
    end
    err_m  = 1'b0;
    last_m = '0;
    tick(1'b0, 1'b0, 1'b0, '0, '0);
    check_cycle("post_rst", 1'b0, 1'b0, '0);
  endtask

  initial begin
    apply_reset(3);

    // Preload word[i] = i through the write port.
    for (int l = 0; l < int'(DEPTH / LW); l++) begin
      for (int k = 0; k < int'(LW); k++) wbuf[k] = 32'(l * LW + k);
      do_write(32'(l * LW * 4), 99, 0, 1'b0);
    end

    do_read(32'h40, 1'b0, '0);

    wbuf[0] = 32'hA0; wbuf[1] = 32'hA1; wbuf[2] = 32'hA2; wbuf[3] = 32'hA3;
    do_write(32'h80, 99, 0, 1'b0);
    do_read(32'h8C, 1'b0, '0);

    wbuf[0] = 32'hB0; wbuf[1] = 32'hB1; wbuf[2] = 32'hB2; wbuf[3] = 32'hB3;
    do_write(32'h104, 1, 3, 1'b0);
    do_read(32'h100, 1'b0, '0);

    do_read(32'h44, 1'b1, 32'hDEAD_BEEF);
    do_read(32'h40, 1'b0, '0);

    // Abort a burst after two valid words.
    tick(1'b0, 1'b1, 1'b0, 32'h80, '0);
    check_cycle("abort_req", 1'b0, 1'b0, '0);
    for (int k = 1; k <= int'(LAT + 1); k++) begin
      tick(1'b0, 1'b0, 1'b0, '0, '0);
      check_cycle("abort_rd", 1'b1, k >= int'(LAT), (k >= int'(LAT)) ? mem_m[32 + k - LAT] : 32'h0);
    end
    apply_reset(1);
    do_read(32'h80, 1'b0, '0);

    do_read(32'hFFFF_F000, 1'b0, '0);

    wbuf[0] = 32'hC0; wbuf[1] = 32'hC1; wbuf[2] = 32'hC2; wbuf[3] = 32'hC3;
    do_write(32'h200, 0, 2, 1'b1);
    do_read(32'h200, 1'b0, '0);
    apply_reset(2);

    for (int t = 0; t < 80; t++) begin
      if ($urandom_range(0, 1) == 0) begin
        do_read($urandom, 1'b0, '0);
      end else begin
        for (int k = 0; k < int'(LW); k++) wbuf[k] = $urandom;
        do_write($urandom, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), 1'b0);
      end
      if ($urandom_range(0, 3) == 0) begin
        tick(1'b0, 1'b0, 1'b0, $urandom, $urandom);
        check_cycle("gap", 1'b0, 1'b0, '0);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/mem_line_responder.md
Name: mem_line_responder

Overview:
- Memory-side responder for the pipeline's cache-miss port, i.e. the far end of the `o_p_waitrequest`-style request/wait handshake.
- Accepts line-fill reads and line write-backs from the cache controller, stalls the initiator with `o_m_waitrequest`, and returns read data as a `readdatavalid` burst after a fixed access latency.
- Holds the backing word store, so stall and forwarding logic can be exercised against realistic miss timing.

Parameters:
- ADDR_W, 32, byte-address width of `i_m_addr`.
- DATA_W, 32, word width.
- LINE_WORDS, 4, words per burst; power of two, at least 2.
- LATENCY, 4, cycles from command acceptance to the first read word, and the busy time after the last write word; at least 1.
- DEPTH_WORDS, 1024, backing store size in words; power of two.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- i_m_read  in  1  line-read request.
- i_m_write  in  1  write request / write-word strobe.
- i_m_addr  in  ADDR_W  byte address of the line; sampled only on command acceptance.
- i_m_writedata  in  DATA_W  write word.
- o_m_waitrequest  out  1  command/word not accepted this cycle.
- o_m_readdata  out  DATA_W  read word.
- o_m_readdatavalid  out  1  `o_m_readdata` valid this cycle.
- o_m_error  out  1  sticky protocol-error flag.

Behaviour:
- Reset (synchronous, also mid-burst):
  - state = IDLE; `o_m_readdatavalid` = 0; `o_m_readdata` = 0; `o_m_error` = 0; counters = 0.
  - `o_m_waitrequest` = 1 while `rst` is high.
  - Store contents are retained; any in-flight burst is aborted with no further `readdatavalid`.
- Addressing:
  - word index = `i_m_addr[2 +: log2(DEPTH_WORDS)]`, so higher address bits wrap modulo depth.
  - line base = word index with its low log2(LINE_WORDS) bits cleared.
  - Burst order is base+0 .. base+LINE_WORDS-1, with no critical-word-first.
- `o_m_waitrequest` is 0 in IDLE and WBURST, and 1 in RLAT, RBURST and WBUSY.
- A transfer is accepted on a rising edge where `i_m_read` or `i_m_write` is high and `o_m_waitrequest` is low.
- State IDLE:
  - `i_m_read` accepted (cycle T): latch base, load latency counter, go to RLAT.
  - `i_m_write` accepted: write `i_m_writedata` to base+0, set word count to 1, go to WBURST.
  - Both high: treated as a read; the write is dropped; `o_m_error` is set.
- State RLAT: count down; `o_m_readdatavalid` is high in cycles T+LATENCY .. T+LATENCY+LINE_WORDS-1, one word per cycle, with no gaps.
- State RBURST: after the last word, go to IDLE. A new command can be accepted in the cycle following the last valid word.
- State WBURST:
  - Each cycle with `i_m_write` high writes the next word and increments the count.
  - `i_m_write` low means the master pauses; the burst is held indefinitely.
  - After word LINE_WORDS-1 is written, go to WBUSY with the counter loaded to LATENCY.
  - `i_m_read` high in WBURST is ignored and sets `o_m_error`.
- State WBUSY: count down LATENCY cycles, then go to IDLE.
- A read of a line that was just written returns the new data; the store is written in the cycle each word is accepted.
- `o_m_readdata` holds its last value when not valid.
- `o_m_error` stays set until reset.

Optional Feature:
- Macro: `MEM_RESP_JITTER_EN`.
- Defined:
  - An 8-bit LFSR (taps 8,6,5,4) is seeded to 0xA5 on reset and advances every cycle.
  - On each command acceptance, the value LFSR[1:0] (0..3) is added to the latency of that RLAT/WBUSY phase.
- Undefined: latency is exactly LATENCY and no LFSR is present.

Decomposition:
- Package `mem_resp_pkg`:
  - state enum {IDLE, RLAT, RBURST, WBURST, WBUSY};
  - LFSR seed and tap constants;
  - localparam helpers for log2 of LINE_WORDS and DEPTH_WORDS.
- Sub-module `resp_word_ram`: single-port synchronous RAM (DEPTH_WORDS x DATA_W), one-cycle registered read, write-enable; the FSM and counters stay in the top.

Test Plan:
- Store preloaded with word[i] = i; read at addr 0x40 (LATENCY=4, LINE_WORDS=4) accepted at cycle 10 -> `o_m_readdatavalid` high in cycles 14..17 carrying 16, 17, 18, 19; `o_m_waitrequest` high in cycles 11..17.
- Write at 0x80 with words A0..A3, presented back-to-back -> WBUSY for 4 cycles, then IDLE; a subsequent read at 0x8C returns A0, A1, A2, A3 in base order.
- Write burst with `i_m_write` dropped for 3 cycles after word 1 -> burst resumes; all four words land at base..base+3; no error.
- `i_m_read` and `i_m_write` both high in IDLE -> a read burst is returned, the store is unchanged, and `o_m_error` = 1 until `rst`.
- `rst` pulsed during RBURST after 2 valid words -> no further `readdatavalid`; the next cycle shows IDLE with `o_m_waitrequest` = 0; store contents intact.
- Address 0xFFFF_F000 with DEPTH_WORDS=1024 -> aliases to word index 0x000; the read returns words 0..3.
